pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage CPU. It generates the enable and flush controls for the PC and for the IF/ID and ID/EX pipeline registers. It detects load-use hazards against the EX stage, owns the FSM that sequences the multi-cycle divide unit, and squashes the wrong-path fetch on taken branches. The EX/MEM and MEM/WB registers are never stalled: a bubble injected at ID/EX drains through them as an ordinary NOP with write/dm-write low.

---
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, divide-unit sequencing and branch squash.
// Optional stall-cycle performance counter under `PIPE_CTRL_PERF_EN`.
//
// state | meaning
// IDLE  | no divide in flight; md_start may fire
// BUSY  | divide unit running, pipeline frozen; cnt counts down to 0
// DONE  | result ready, divide instruction advances to EX this cycle
module pipe_hazard_ctrl #(
    parameter int DIV_LATENCY = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       use_rs_id,
    input  logic       use_rt_id,
    input  logic       is_lw_ex,
    input  logic       write_ex,
    input  logic [4:0] w_addr_ex,
    input  logic       is_md_id,
    input  logic       branch_taken_id,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       md_start,
    output logic       md_busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [7:0] cnt;
    logic       lu_hazard;
    logic       md_go;
    logic       md_stall;
    logic       stall;

    assign lu_hazard = is_lw_ex & write_ex & (w_addr_ex != 5'd0) &
                       ((use_rs_id & (rs_id == w_addr_ex)) |
                        (use_rt_id & (rt_id == w_addr_ex)));

    // A pending load-use hazard holds off the divide start until the load has moved on.
    assign md_go    = (state == IDLE) & is_md_id & ~lu_hazard;
    assign md_stall = md_go | (state == BUSY);
    assign stall    = lu_hazard | md_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_go) begin
                        state <= BUSY;
                        cnt   <= 8'(DIV_LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt == 8'd0) state <= DONE;
                    else             cnt   <= cnt - 8'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        md_start    = 1'b0;
        md_busy     = 1'b0;
        if (!rst_n) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            md_start = md_go;
            md_busy  = (state == BUSY);
            if (stall) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (branch_taken_id) begin
                if_id_flush = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cycles <= 32'd0;
        else if (!pc_en && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
